// File: rtl/mem_loader.sv
// Streams words from a valid/ready source into consecutive memory addresses,
// starting at a latched base and wrapping modulo the address space.
module mem_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;

  // abort blocks the handshake so a cancelled cycle never transfers a word
  assign s_ready = (state == LOAD) && !abort;
  assign busy    = (state == LOAD);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            if (len != '0) begin
              state     <= LOAD;
              ptr       <= base;
              remaining <= len;
            end else begin
              state <= DONE;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else if (s_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= s_data;
            ptr       <= ptr + 1'b1;
            remaining <= remaining - ONE;
            count     <= count + ONE;
            // the final write and the done pulse land in the same cycle
            if (remaining == ONE) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 4, memory address width in bits.
REQ-002 The module SHALL have parameter DATA_W, default 8, memory data width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 base  input  ADDR_W  first write address; latched when start is accepted.
REQ-007 len  input  ADDR_W+1  number of words to write (0..2^ADDR_W); latched when start is accepted.
REQ-008 abort  input  1  synchronous cancel of a load in progress.
REQ-009 s_valid  input  1  source word valid.
REQ-010 s_data  input  DATA_W  source word.
REQ-011 s_ready  output  1  loader can accept a word.
REQ-012 mem_we  output  1  memory write enable, registered.
REQ-013 mem_addr  output  ADDR_W  memory write address, registered.
REQ-014 mem_wdata  output  DATA_W  memory write data, registered.
REQ-015 busy  output  1  high in LOAD.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 count  output  ADDR_W+1  words written in the current or last load.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, LOAD, DONE.
REQ-019 IDLE: start=1 with len!=0 SHALL move to LOAD, latch base into the address pointer, latch len into the remaining counter, and clear count.
REQ-020 IDLE: start=1 with len==0 SHALL move directly to DONE with no write, and clear count.
REQ-021 start SHALL be ignored in LOAD and DONE.
REQ-022 s_ready SHALL equal (state==LOAD && !abort), combinationally.
REQ-023 A beat SHALL transfer in any cycle where s_valid && s_ready; s_data is not sampled otherwise.
REQ-024 A beat accepted in cycle N SHALL produce mem_we=1, mem_addr=pointer, mem_wdata=s_data in cycle N+1 (latency 1); mem_we SHALL be 0 in every other cycle.
REQ-025 After each beat the pointer SHALL increment modulo 2^ADDR_W (wrap from all-ones to 0), remaining SHALL decrement, and count SHALL increment.
REQ-026 When the beat that brings remaining to 0 transfers, the FSM SHALL move to DONE; the final mem_we and done SHALL be high in the same cycle.
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-028 A source stall (s_valid=0) in LOAD SHALL hold all state; no timeout.
REQ-029 abort=1 in LOAD SHALL return to IDLE next cycle, with no done pulse and no transfer in that cycle; writes already registered complete; count holds the words written.
REQ-030 abort SHALL be ignored in IDLE and DONE.
REQ-031 len > 2^ADDR_W is impossible by width; len == 2^ADDR_W SHALL write every address exactly once, starting at base and wrapping.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, done=0, busy=0, count=0, and clear the pointer and remaining counter, regardless of clock.
REQ-033 Reset asserted mid-load SHALL discard the load with no further mem_we and no done pulse; after release the block SHALL be in IDLE awaiting start.

Verification
REQ-034 base=0x2, len=3, data A0,A1,A2 streamed back-to-back -> mem_we on 3 consecutive cycles at addr 2,3,4 with A0..A2; done high alongside the last write; count=3.
REQ-035 base=0xE, len=4, data 11,22,33,44 -> writes at addr E,F,0,1 (wrap); done once; count=4.
REQ-036 base=0x5, len=2, s_valid toggled 1,0,0,1 -> exactly 2 writes at addr 5,6, each one cycle after its handshake; no write during the gaps.
REQ-037 start with len=0 -> no mem_we; done pulses exactly one cycle later; count=0.
REQ-038 base=0x0, len=8, abort asserted after 3 beats -> writes at addr 0,1,2 only; s_ready low in the abort cycle; no done; count=3; a following start is accepted normally.
REQ-039 rst_n pulsed low asynchronously after 2 of 5 beats -> all outputs 0 at once; no done; after release start with base=0x9, len=1 writes addr 9.
